keypad_scanner: RTL and testbench

Scans a 4x4 hex keypad (Digilent Pmod KYPD on a Basys3 Pmod header) and turns key presses into debounced hex key events. It is the input-side counterpart of the multiplexed seven-segment display path: it time-multiplexes column strobes, samples the row returns, debounces whole-keypad scans, and hands each new key to the core over a valid/ready handshake. Its `key_code` output matches the 4-bit hex digit format the display driver consumes.

---
 rtl/keypad_pkg.sv | 31 +++
 rtl/keypad_scanner_sync_2ff.sv | 14 +
 rtl/keypad_scanner.sv | 86 ++++++++
 tb/tb_keypad_scanner.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// keypad_pkg: shared types, the keypad code map, and the scan classifier for keypad_scanner
package keypad_pkg;
  typedef enum logic [1:0] {NONE, KEY, MULTI} scan_kind_e;
  typedef enum logic {RELEASED, HELD} kp_state_e;
  typedef struct packed {
    scan_kind_e kind;
    logic [3:0] code;
  } scan_res_t;
  localparam logic [3:0] KEYMAP [4][4] = '{
    '{4'h1, 4'h4, 4'h7, 4'h0},
    '{4'h2, 4'h5, 4'h8, 4'hF},
    '{4'h3, 4'h6, 4'h9, 4'hE},
    '{4'hA, 4'hB, 4'hC, 4'hD}
  };
  // map bit c*4+r is set when the key at column c, row r reads pressed
  function automatic scan_res_t classify(input logic [15:0] map);
    scan_res_t r;
    int n;
    r = '{NONE, 4'h0};
    n = 0;
    for (int c = 0; c < 4; c++)
      for (int w = 0; w < 4; w++)
        if (map[c*4+w]) begin
          n++;
          r.code = KEYMAP[c][w];
        end
    r.kind = n == 0 ? NONE : n == 1 ? KEY : MULTI;
    if (n != 1) r.code = 4'h0;
    return r;
  endfunction
endpackage

// File: rtl/keypad_scanner_sync_2ff.sv
// sync_2ff: two-flop synchronizer resetting to all-ones; clk, reset (async high), d (async in), q (synced out)
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] meta;
  always_ff @(posedge clk or posedge reset)
    if (reset) {q, meta} <= '1;
    else {q, meta} <= {meta, d};
endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 keypad column scan, whole-scan debounce, press FSM and valid/ready key events; col (strobes out), row (returns in), key_code/key_valid/key_ready (event handshake), key_down (held level), overrun (sticky drop flag)
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SETTLE_CYCLES  = 100_000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       reset,
  output logic [3:0] col,
  input  logic [3:0] row,
  output logic [3:0] key_code,
  output logic       key_valid,
  input  logic       key_ready,
  output logic       key_down,
  output logic       overrun
);
  localparam int SW = $clog2(SETTLE_CYCLES);
  localparam int DW = $clog2(DEBOUNCE_SCANS);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
  localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_SCANS - 1);
  logic [3:0] row_s;
  logic [SW-1:0] settle_cnt;
  logic [1:0] col_idx;
  logic [15:0] press_map;
  logic [DW-1:0] stable_cnt;
  scan_res_t res, prev;
  kp_state_e state, state_nx;
  logic tc, scan_done, same, stable, ev;
  sync_2ff #(.WIDTH(4)) u_sync (.clk(clk), .reset(reset), .d(row), .q(row_s));
  assign tc = settle_cnt == SETTLE_LAST;
  assign scan_done = tc && col_idx == 2'd3;
  // column 3 is folded in directly so the result is ready on its sample edge
  assign res = classify({~row_s, press_map[11:0]});
  assign same = res == prev;
  // stable once the count after this agreeing scan reaches DEB_LAST
  assign stable = scan_done && same && stable_cnt >= DEB_LAST - DW'(1);
  assign key_down = state == HELD;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      settle_cnt <= '0;
      col_idx <= 2'd0;
      col <= 4'b1110;
      press_map <= '0;
    end else begin
      settle_cnt <= tc ? '0 : settle_cnt + SW'(1);
      if (tc) begin
        col_idx <= col_idx + 2'd1;
        col <= ~(4'b0001 << (col_idx + 2'd1));
      end
      if (scan_done) press_map <= '0;
      else if (tc) press_map[{col_idx, 2'b00} +: 4] <= ~row_s;
    end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      prev <= '{NONE, 4'h0};
      stable_cnt <= '0;
    end else if (scan_done) begin
      if (same) stable_cnt <= stable_cnt == DEB_LAST ? stable_cnt : stable_cnt + DW'(1);
      else begin
        prev <= res;
        stable_cnt <= '0;
      end
    end
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= RELEASED;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    ev = 1'b0;
    if (stable && state == RELEASED && res.kind == KEY) begin
      state_nx = HELD;
      ev = 1'b1;
    end else if (stable && state == HELD && res.kind == NONE) state_nx = RELEASED;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      key_code <= 4'h0;
      key_valid <= 1'b0;
      overrun <= 1'b0;
    end else if (ev && key_valid && !key_ready) overrun <= 1'b1;
    else if (ev) begin
      key_code <= res.code;
      key_valid <= 1'b1;
    end else if (key_valid && key_ready) key_valid <= 1'b0;
endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: keypad model plus event scoreboard exercising scan, debounce, ghosting, backpressure and reset
module tb_keypad_scanner;
  localparam int SCAN = 32;
  logic clk = 1'b0, reset = 1'b1, key_ready = 1'b0;
  logic [3:0] col, row, key_code;
  logic key_valid, key_down, overrun;
  logic [15:0] pressed = '0;
  logic [3:0] exp_q[$], obs_q[$];
  logic [3:0] e, o;
  int tests = 0, fails = 0;
  always #5 clk = ~clk;
  keypad_scanner #(.SETTLE_CYCLES(8), .DEBOUNCE_SCANS(3)) dut (
    .clk(clk), .reset(reset), .col(col), .row(row), .key_code(key_code),
    .key_valid(key_valid), .key_ready(key_ready), .key_down(key_down), .overrun(overrun)
  );
  always_comb begin
    row = 4'b1111;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        if (pressed[c*4+r] && !col[c]) row[r] = 1'b0;
  end
  always @(negedge clk) if (!reset && key_valid && key_ready) obs_q.push_back(key_code);
  task automatic run(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask
  task automatic test_reset;
    logic [3:0] ec;
    run(3);
    @(negedge clk);
    tests++; if (col !== 4'b1110) begin fails++; $display("FAIL reset_col: got %b, expected 1110", col); end
    tests++; if (key_code !== 4'h0) begin fails++; $display("FAIL reset_code: got %h, expected 0", key_code); end
    tests++; if (key_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b, expected 0", key_valid); end
    tests++; if (key_down !== 1'b0) begin fails++; $display("FAIL reset_down: got %b, expected 0", key_down); end
    tests++; if (overrun !== 1'b0) begin fails++; $display("FAIL reset_overrun: got %b, expected 0", overrun); end
    @(posedge clk);
    #2 reset = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      run(1);
      ec = ~(4'b0001 << ((n / 8) % 4));
      tests++; if (col !== ec) begin fails++; $display("FAIL scan_col cycle %0d: got %b, expected %b", n, col, ec); end
    end
  endtask
  task automatic test_single_press;
    key_ready = 1'b1;
    pressed[5] = 1'b1;
    exp_q.push_back(4'h5);
    run(5 * SCAN);
    tests++; if (key_down !== 1'b1) begin fails++; $display("FAIL press_down: got %b, expected 1", key_down); end
    tests++; if (obs_q.size() !== exp_q.size()) begin fails++; $display("FAIL press_events: got %0d, expected %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      tests++; if (o !== e) begin fails++; $display("FAIL press_code: got %h, expected %h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
    pressed[5] = 1'b0;
    run(5 * SCAN);
    tests++; if (key_down !== 1'b0) begin fails++; $display("FAIL release_down: got %b, expected 0", key_down); end
    tests++; if (obs_q.size() !== 0) begin fails++; $display("FAIL release_events: got %0d, expected 0", obs_q.size()); end
    obs_q.delete();
  endtask
  task automatic test_bounce;
    for (int i = 0; i < 13; i++) begin
      pressed[10] = ~pressed[10];
      run(5);
    end
    pressed[10] = 1'b1;
    exp_q.push_back(4'h9);
    run(5 * SCAN);
    tests++; if (obs_q.size() !== exp_q.size()) begin fails++; $display("FAIL bounce_events: got %0d, expected %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      tests++; if (o !== e) begin fails++; $display("FAIL bounce_code: got %h, expected %h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
    pressed[10] = 1'b0;
    run(5 * SCAN);
    obs_q.delete();
  endtask
  task automatic test_ghosting;
    pressed[0] = 1'b1;
    pressed[4] = 1'b1;
    run(5 * SCAN);
    tests++; if (obs_q.size() !== 0) begin fails++; $display("FAIL ghost_events: got %0d, expected 0", obs_q.size()); end
    tests++; if (key_down !== 1'b0) begin fails++; $display("FAIL ghost_down: got %b, expected 0", key_down); end
    obs_q.delete();
    pressed[4] = 1'b0;
    exp_q.push_back(4'h1);
    run(5 * SCAN);
    tests++; if (key_down !== 1'b1) begin fails++; $display("FAIL ghost_single_down: got %b, expected 1", key_down); end
    tests++; if (obs_q.size() !== exp_q.size()) begin fails++; $display("FAIL ghost_single_events: got %0d, expected %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      tests++; if (o !== e) begin fails++; $display("FAIL ghost_code: got %h, expected %h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
    pressed[0] = 1'b0;
    run(5 * SCAN);
    obs_q.delete();
  endtask
  task automatic test_backpressure;
    key_ready = 1'b0;
    pressed[12] = 1'b1;
    run(5 * SCAN);
    tests++; if (key_valid !== 1'b1) begin fails++; $display("FAIL bp_valid: got %b, expected 1", key_valid); end
    pressed[12] = 1'b0;
    run(5 * SCAN);
    pressed[15] = 1'b1;
    run(5 * SCAN);
    tests++; if (key_code !== 4'hA) begin fails++; $display("FAIL bp_code_kept: got %h, expected a", key_code); end
    tests++; if (overrun !== 1'b1) begin fails++; $display("FAIL bp_overrun: got %b, expected 1", overrun); end
    tests++; if (key_down !== 1'b1) begin fails++; $display("FAIL bp_down: got %b, expected 1", key_down); end
    exp_q.push_back(4'hA);
    key_ready = 1'b1;
    run(1);
    tests++; if (key_valid !== 1'b0) begin fails++; $display("FAIL bp_accept_valid: got %b, expected 0", key_valid); end
    tests++; if (overrun !== 1'b1) begin fails++; $display("FAIL bp_overrun_sticky: got %b, expected 1", overrun); end
    tests++; if (obs_q.size() !== exp_q.size()) begin fails++; $display("FAIL bp_events: got %0d, expected %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      tests++; if (o !== e) begin fails++; $display("FAIL bp_accept_code: got %h, expected %h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
    pressed[15] = 1'b0;
    run(5 * SCAN);
    obs_q.delete();
  endtask
  task automatic test_reset_mid;
    key_ready = 1'b0;
    pressed[5] = 1'b1;
    run(5 * SCAN);
    tests++; if (key_valid !== 1'b1) begin fails++; $display("FAIL mid_pending: got %b, expected 1", key_valid); end
    run(3);
    #1 reset = 1'b1;
    #1;
    tests++; if (key_valid !== 1'b0) begin fails++; $display("FAIL mid_valid: got %b, expected 0", key_valid); end
    tests++; if (col !== 4'b1110) begin fails++; $display("FAIL mid_col: got %b, expected 1110", col); end
    tests++; if (overrun !== 1'b0) begin fails++; $display("FAIL mid_overrun: got %b, expected 0", overrun); end
    tests++; if (key_down !== 1'b0) begin fails++; $display("FAIL mid_down: got %b, expected 0", key_down); end
    pressed[5] = 1'b0;
    run(2);
    reset = 1'b0;
    run(7);
    tests++; if (col !== 4'b1110) begin fails++; $display("FAIL restart_col0: got %b, expected 1110", col); end
    run(1);
    tests++; if (col !== 4'b1101) begin fails++; $display("FAIL restart_col1: got %b, expected 1101", col); end
  endtask
  initial begin
    test_reset;
    test_single_press;
    test_bounce;
    test_ghosting;
    test_backpressure;
    test_reset_mid;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
